sram_bus_arbiter: RTL
=====================

Name: sram_bus_arbiter

Overview:
- Shares one unified memory port (req/addr_ok/data_ok handshake) between the instruction-fetch requester (IF stage) and the data requester (EX/MEM stage).
- Sits between the pipeline stages and the external bus bridge.
- Arbitrates with data priority and a starvation guard for instruction fetch.
- Exposes per-requester handshakes and a busy flag that feeds the stall controller.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- STARVE_LIMIT, 4, consecutive data grants allowed while an inst request waits; range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- inst_req  in  1  fetch request; held until inst_addr_ok.
- inst_addr  in  ADDR_W  fetch address.
- inst_addr_ok  out  1  fetch address accepted.
- inst_data_ok  out  1  fetch data valid.
- inst_rdata  out  DATA_W  fetch data.
- data_req  in  1  data request; held until data_addr_ok.
- data_wr  in  1  1 = store, 0 = load.
- data_wstrb  in  DATA_W/8  byte strobes (stores).
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_addr_ok  out  1  data address accepted.
- data_data_ok  out  1  load data valid / store done.
- data_rdata  out  DATA_W  load data.
- mem_req  out  1  downstream request.
- mem_wr  out  1  downstream write.
- mem_wstrb  out  DATA_W/8  downstream strobes; 0 for reads.
- mem_addr  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_addr_ok  in  1  downstream accepted the request.
- mem_data_ok  in  1  downstream response valid.
- mem_rdata  in  DATA_W  downstream read data.
- busy  out  1  a transaction is in flight (state != IDLE).

Behaviour:
- FSM states: IDLE, ADDR, WAIT. One outstanding transaction at a time.
- IDLE:
  - If inst_req or data_req is high, pick a winner, register owner and its fields (wr, wstrb, addr, wdata; inst transactions have wr=0, wstrb=0), go to ADDR.
  - Otherwise stay in IDLE.
- Winner selection:
  - Data wins, except inst wins when inst_req=1 and starve_cnt==STARVE_LIMIT.
  - If only one request is high, that one wins.
- starve_cnt (4-bit):
  - +1 on a data grant while inst_req=1, saturating at STARVE_LIMIT.
  - Cleared on an inst grant, and on any IDLE cycle with inst_req=0.
- ADDR:
  - mem_req=1; mem_* driven from the registered fields and held stable until mem_addr_ok.
  - Owner's x_addr_ok = mem_addr_ok (combinational, only in ADDR, owner only).
  - On mem_addr_ok go to WAIT.
- ADDR with mem_addr_ok and mem_data_ok in the same cycle:
  - Both handshakes pulse to the owner in that cycle; go directly to IDLE.
- WAIT:
  - mem_req=0.
  - On mem_data_ok: owner's x_data_ok=1 and x_rdata=mem_rdata (combinational pass); go to IDLE.
- Idle-cycle rules:
  - One IDLE cycle always separates transactions. Minimum cost is 3 cycles per transaction with zero-wait memory.
  - Non-owner addr_ok/data_ok are always 0.
- Protocol-violation inputs, all ignored (no state change, no pulses):
  - mem_data_ok in IDLE.
  - mem_data_ok in ADDR without mem_addr_ok.
  - mem_addr_ok outside ADDR.
- Requester changes during a transaction: a requester dropping or changing its req or fields after the grant has no effect; the latched copy is used.
- x_rdata when x_data_ok=0: 0.
- Reset values:
  - State IDLE; starve_cnt 0.
  - All registered fields 0.
  - mem_req, busy, all *_ok outputs, and rdata outputs all 0.
- Reset mid-transaction: aborts immediately (asynchronous). Any later mem_data_ok is ignored because the FSM is in IDLE.

Test Plan:
- Single load: data_req=1, data_addr=0x1000, wr=0; mem_addr_ok at cycle 2, mem_data_ok at cycle 4 with rdata=0xDEADBEEF -> mem_req=1 only in cycles 1-2; data_addr_ok at cycle 2; data_data_ok with data_rdata=0xDEADBEEF at cycle 4; busy high cycles 1-4.
- Simultaneous requests: inst_req and data_req both high at cycle 0 (store 0x2000, wstrb=4'b0011) -> data granted first with mem_wr=1, mem_wstrb=4'b0011; inst granted in the next IDLE; inst outputs stay 0 throughout the data transaction.
- Starvation guard with STARVE_LIMIT=4: inst_req and data_req held high continuously, zero-wait memory -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each inst grant.
- Same-cycle handshake: in ADDR, mem_addr_ok=1 and mem_data_ok=1 together -> both owner pulses in that cycle; FSM back in IDLE next cycle; no WAIT cycle occurs.
- Reset in WAIT: inst transaction outstanding, rst driven low -> busy and mem_req 0 immediately; after reset release, a stray mem_data_ok produces no inst_data_ok/data_data_ok pulse.
- Field stability: change data_addr from 0x1000 to 0x3000 while in ADDR with mem_addr_ok held low for 3 cycles -> mem_addr stays 0x1000 until accepted.

Source files
------------

// File: rtl/sram_bus_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sram_bus_arbiter_if : requester and memory-side signal bundle of the arbiter
// Rev 1.0
// ============================================================================
interface sram_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  inst_req;
  logic [ADDR_W-1:0]     inst_addr;
  logic                  inst_addr_ok;
  logic                  inst_data_ok;
  logic [DATA_W-1:0]     inst_rdata;

  logic                  data_req;
  logic                  data_wr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  logic                  mem_req;
  logic                  mem_wr;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_addr_ok;
  logic                  mem_data_ok;
  logic [DATA_W-1:0]     mem_rdata;

  // Arbiter view: requester side is served, memory side is driven.
  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sram_bus_arbiter : shares one memory port between fetch and data requesters
// Rev 1.0
// ============================================================================
module sram_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  sram_bus_arbiter_if.slave bus,
  output logic              busy
);
  localparam int         STRB_W     = DATA_W / 8;
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ADDR     = 2'd1;
  localparam logic [1:0] S_WAIT     = 2'd2;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              own_data_q, own_data_d;
  logic              wr_q, wr_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_inst;
  logic              addr_hs;
  logic              data_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      starve_q   <= '0;
      own_data_q <= 1'b0;
      wr_q       <= 1'b0;
      wstrb_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      own_data_q <= own_data_d;
      wr_q       <= wr_d;
      wstrb_q    <= wstrb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Data has priority unless the fetch side has waited STARVE_LIMIT grants.
  assign grant_inst = bus.inst_req && (!bus.data_req || (starve_q == STARVE_MAX));

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    own_data_d = own_data_q;
    wr_d       = wr_q;
    wstrb_d    = wstrb_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.inst_req) starve_d = '0;
        if (bus.inst_req || bus.data_req) begin
          state_d = S_ADDR;
          if (grant_inst) begin
            own_data_d = 1'b0;
            wr_d       = 1'b0;
            wstrb_d    = '0;
            addr_d     = bus.inst_addr;
            wdata_d    = '0;
            starve_d   = '0;
          end else begin
            own_data_d = 1'b1;
            wr_d       = bus.data_wr;
            wstrb_d    = bus.data_wr ? bus.data_wstrb : '0;
            addr_d     = bus.data_addr;
            wdata_d    = bus.data_wdata;
            if (bus.inst_req && (starve_q < STARVE_MAX)) starve_d = starve_q + 4'd1;
          end
        end
      end
      S_ADDR: begin
        if (bus.mem_addr_ok) state_d = bus.mem_data_ok ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A response counts in WAIT, or in ADDR only together with the address handshake.
  always_comb begin
    addr_hs          = (state_q == S_ADDR) && bus.mem_addr_ok;
    data_hs          = ((state_q == S_WAIT) && bus.mem_data_ok) || (addr_hs && bus.mem_data_ok);
    busy             = (state_q != S_IDLE);
    bus.mem_req      = (state_q == S_ADDR);
    bus.mem_wr       = wr_q;
    bus.mem_wstrb    = wstrb_q;
    bus.mem_addr     = addr_q;
    bus.mem_wdata    = wdata_q;
    bus.inst_addr_ok = addr_hs && !own_data_q;
    bus.data_addr_ok = addr_hs && own_data_q;
    bus.inst_data_ok = data_hs && !own_data_q;
    bus.data_data_ok = data_hs && own_data_q;
    bus.inst_rdata   = (data_hs && !own_data_q) ? bus.mem_rdata : '0;
    bus.data_rdata   = (data_hs && own_data_q) ? bus.mem_rdata : '0;
  end
endmodule
`default_nettype wire
